oram_arb: RTL and testbench
===========================

ORAM_ARB -- requirements
Module: oram_arb

Interface
REQ-001 SHALL have parameter AW, default 12, SRAM word-address width.
REQ-002 SHALL have parameter DW, default 32, SRAM data width.
REQ-003 SHALL have parameter LW, default 4, burst-length field width; beats = len+1.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port req  input  3  per-requester burst request; 0=conv, 1=act/pool, 2=store.
REQ-007 SHALL have port req_we  input  3  per-requester write (1) / read (0).
REQ-008 SHALL have port req_addr  input  3*AW  per-requester start address, slice i at [AW*i+:AW].
REQ-009 SHALL have port req_len  input  3*LW  per-requester len, slice i at [LW*i+:LW].
REQ-010 SHALL have port req_wdata  input  3*DW  per-requester write data for current beat.
REQ-011 SHALL have port flush  input  1  abort active burst.
REQ-012 SHALL have port gnt  output  3  one-hot owner, held for whole burst.
REQ-013 SHALL have port beat  output  3  one-hot; owner's beat issued this cycle, owner advances wdata next cycle.
REQ-014 SHALL have port rvld  output  3  one-hot read-data valid to requester.
REQ-015 SHALL have port rdata  output  DW  read data, shared by all requesters.
REQ-016 SHALL have port busy  output  1  state is BURST.
REQ-017 SHALL have ports sram_en/sram_we (1 each), sram_addr (AW), sram_wdata (DW) as outputs, sram_rdata (DW) as input; SRAM read latency one cycle.

Function
REQ-018 SHALL implement FSM IDLE/BURST; IDLE->BURST when any req in IDLE; BURST->IDLE after last beat or on flush.
REQ-019 SHALL, in IDLE, pick winner round-robin starting at ptr+1 mod 3, latch owner, we, addr, len; gnt rises next cycle.
REQ-020 SHALL update ptr to owner when winner is latched.
REQ-021 SHALL, each BURST cycle, drive sram_en=1, sram_we=latched we, sram_addr=base+cnt, sram_wdata=owner req_wdata, beat[owner]=1.
REQ-022 SHALL increment cnt per beat; cnt==latched len is last beat; gnt and busy drop on the following cycle.
REQ-023 SHALL add address modulo 2^AW (0xFFF+1 -> 0x000, no error).
REQ-024 SHALL ignore req changes, including owner deasserting req, during BURST; burst always runs to completion unless flushed.
REQ-025 SHALL, on flush in BURST, issue no beat that cycle (sram_en=0), go IDLE next edge; flush in IDLE has no effect.
REQ-026 SHALL assert rvld[owner] and rdata=sram_rdata one cycle after each read beat, including the final beat before a flush.
REQ-027 SHALL insert exactly one IDLE cycle between consecutive bursts; max throughput (len+1)/(len+2).
REQ-028 SHALL keep sram_en=0 and beat=0 whenever not in BURST.

Reset
REQ-029 SHALL, on rst high at clock edge, force IDLE, cnt=0, ptr=2, gnt=0, beat=0, rvld=0, busy=0, sram_en=0, sram_we=0, sram_addr=0, rdata=0.
REQ-030 SHALL, on rst mid-burst, abandon burst immediately; pending rvld is dropped.

Configuration
REQ-031 SHALL, with ORAM_ARB_FIXED_PRIO_EN defined, use fixed priority 0>1>2, ignoring ptr.
REQ-032 SHALL, without ORAM_ARB_FIXED_PRIO_EN, use the round-robin of REQ-019/020.

Verification
REQ-033 SHALL cover: req=3'b001, we=1, addr=0x010, len=3 -> gnt=001 four cycles, sram_addr 0x010..0x013, four beat[0] pulses, then IDLE.
REQ-034 SHALL cover: req=3'b111 held, all len=0, from reset -> grant order 0,1,2,0 (ORAM_ARB_FIXED_PRIO_EN: 0,0,0,0).
REQ-035 SHALL cover: read burst addr=0xFFE, len=2 -> sram_addr 0xFFE,0xFFF,0x000; rvld[owner] three cycles, each one cycle after its beat.
REQ-036 SHALL cover: flush on third beat of len=7 burst -> two beats issued, sram_en=0 on flush cycle, IDLE next cycle, ptr = flushed owner.
REQ-037 SHALL cover: owner drops req after first beat of len=3 -> all four beats still issued.
REQ-038 SHALL cover: rst asserted on second beat -> next cycle all outputs at reset values, no further rvld.

Source files
------------

// File: rtl/oram_arb.sv
// Purpose : three-requester burst arbiter in front of a single-port SRAM (conv / act-pool / store).
// Latency : grant one cycle after req is seen in IDLE; one beat per cycle; read data one cycle after its beat.
// Backpres: none on the SRAM side; requesters wait in IDLE, owner paces wdata from its beat pulse.
//
// Ports:
//   clk, rst            single clock, synchronous active-high reset
//   req/req_we          per-requester burst request and direction (1=write)
//   req_addr/req_len    per-requester start address and len (beats = len+1), slice i at [W*i +: W]
//   req_wdata           per-requester write data for the current beat
//   flush               abort the active burst (no beat that cycle)
//   gnt/beat/rvld       one-hot owner, beat-issued strobe, read-data valid
//   rdata               read data shared by all requesters
//   busy                a burst is in progress
//   sram_*              SRAM port, read latency one cycle
//
// Build option: define ORAM_ARB_FIXED_PRIO_EN for fixed priority 0 > 1 > 2 instead of round-robin.

module oram_arb #(
    parameter int AW = 12,
    parameter int DW = 32,
    parameter int LW = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [2:0]      req,
    input  logic [2:0]      req_we,
    input  logic [3*AW-1:0] req_addr,
    input  logic [3*LW-1:0] req_len,
    input  logic [3*DW-1:0] req_wdata,
    input  logic            flush,
    output logic [2:0]      gnt,
    output logic [2:0]      beat,
    output logic [2:0]      rvld,
    output logic [DW-1:0]   rdata,
    output logic            busy,
    output logic            sram_en,
    output logic            sram_we,
    output logic [AW-1:0]   sram_addr,
    output logic [DW-1:0]   sram_wdata,
    input  logic [DW-1:0]   sram_rdata
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    // Burst context captured when the winner is latched; req changes are ignored afterwards.
    typedef struct packed {
        logic [1:0]    owner;
        logic          we;
        logic [AW-1:0] base;
        logic [LW-1:0] len;
    } burst_t;

    state_t        state_q, state_d;
    burst_t        cur_q;
    burst_t        cand;
    logic [LW-1:0] cnt_q;
    logic [1:0]    ptr_q;
    logic [2:0]    rvld_q;
    logic [1:0]    win;
    logic [2:0]    owner_oh;
    logic [DW-1:0] owner_wdata;
    logic          last_beat;
    logic          beat_issue;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
`ifdef ORAM_ARB_FIXED_PRIO_EN
    always_comb begin
        win = 2'd2;
        if (req[0]) begin
            win = 2'd0;
        end else if (req[1]) begin
            win = 2'd1;
        end
    end
`else
    function automatic logic [1:0] nxt(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    logic [1:0] c0, c1, c2;

    // Search order starts one past the last owner so every requester gets a turn.
    always_comb begin
        c0  = nxt(ptr_q);
        c1  = nxt(c0);
        c2  = nxt(c1);
        win = c2;
        if (req[c0]) begin
            win = c0;
        end else if (req[c1]) begin
            win = c1;
        end
    end
`endif

    // Context of the current winner, captured only in IDLE.
    always_comb begin
        cand       = '0;
        cand.owner = win;
        case (win)
            2'd0: begin
                cand.we   = req_we[0];
                cand.base = req_addr[0 +: AW];
                cand.len  = req_len[0 +: LW];
            end
            2'd1: begin
                cand.we   = req_we[1];
                cand.base = req_addr[AW +: AW];
                cand.len  = req_len[LW +: LW];
            end
            default: begin
                cand.we   = req_we[2];
                cand.base = req_addr[2*AW +: AW];
                cand.len  = req_len[2*LW +: LW];
            end
        endcase
    end

    // Owner decode and its live write data (owner advances wdata after each beat).
    always_comb begin
        case (cur_q.owner)
            2'd0: begin
                owner_oh    = 3'b001;
                owner_wdata = req_wdata[0 +: DW];
            end
            2'd1: begin
                owner_oh    = 3'b010;
                owner_wdata = req_wdata[DW +: DW];
            end
            default: begin
                owner_oh    = 3'b100;
                owner_wdata = req_wdata[2*DW +: DW];
            end
        endcase
    end

    assign last_beat = (cnt_q == cur_q.len);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = BURST;
                end
            end
            BURST: begin
                // Flush wins over a pending last beat: nothing is issued in a flush cycle.
                if (flush || last_beat) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy       = (state_q == BURST);
        beat_issue = busy && !flush;
        gnt        = busy ? owner_oh : 3'b000;
        beat       = beat_issue ? owner_oh : 3'b000;
        sram_en    = beat_issue;
        sram_we    = beat_issue && cur_q.we;
        // Address wraps modulo 2^AW by truncation of the sum.
        sram_addr  = beat_issue ? (cur_q.base + AW'(cnt_q)) : '0;
        sram_wdata = beat_issue ? owner_wdata : '0;
        rvld       = rvld_q;
        rdata      = (|rvld_q) ? sram_rdata : '0;
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_q  <= '0;
            cnt_q  <= '0;
            ptr_q  <= 2'd2;
            rvld_q <= 3'b000;
        end else begin
            // Read data returns one cycle after the beat; reset drops anything in flight.
            rvld_q <= (beat_issue && !cur_q.we) ? owner_oh : 3'b000;
            if (state_q == IDLE) begin
                cnt_q <= '0;
                if (|req) begin
                    cur_q <= cand;
                    ptr_q <= win;
                end
            end else if (flush || last_beat) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + LW'(1);
            end
        end
    end

endmodule

// File: tb/tb_oram_arb.sv
module tb_oram_arb;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int LW = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [2:0]      req;
    logic [2:0]      req_we;
    logic [3*AW-1:0] req_addr;
    logic [3*LW-1:0] req_len;
    logic [3*DW-1:0] req_wdata;
    logic            flush;
    logic [2:0]      gnt;
    logic [2:0]      beat;
    logic [2:0]      rvld;
    logic [DW-1:0]   rdata;
    logic            busy;
    logic            sram_en;
    logic            sram_we;
    logic [AW-1:0]   sram_addr;
    logic [DW-1:0]   sram_wdata;
    logic [DW-1:0]   sram_rdata = '0;

    int vectors = 0;
    int errs    = 0;

    oram_arb #(.AW(AW), .DW(DW), .LW(LW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_len    (req_len),
        .req_wdata  (req_wdata),
        .flush      (flush),
        .gnt        (gnt),
        .beat       (beat),
        .rvld       (rvld),
        .rdata      (rdata),
        .busy       (busy),
        .sram_en    (sram_en),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    always #5 clk = ~clk;

    // Unwritten locations read back a fixed pattern derived from the address.
    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        return 32'h5A5A_0000 | DW'(a);
    endfunction

    // SRAM model, one-cycle read latency.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    bit            wr  [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (sram_en) begin
            if (sram_we) begin
                mem[sram_addr] <= sram_wdata;
                wr[sram_addr]  <= 1'b1;
            end else begin
                sram_rdata <= wr[sram_addr] ? mem[sram_addr] : pat(sram_addr);
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    logic [AW-1:0] wrap_a [3];
    logic [2:0]    order  [7];
    logic [2:0]    after_flush_gnt;

    initial begin
        wrap_a = '{12'hFFE, 12'hFFF, 12'h000};
`ifdef ORAM_ARB_FIXED_PRIO_EN
        order           = '{3'b001, 3'b000, 3'b001, 3'b000, 3'b001, 3'b000, 3'b001};
        after_flush_gnt = 3'b001;
`else
        order           = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001};
        after_flush_gnt = 3'b100;
`endif

        rst       = 1'b1;
        req       = 3'b000;
        req_we    = 3'b000;
        req_addr  = '0;
        req_len   = '0;
        req_wdata = '0;
        flush     = 1'b0;
        step();
        step();

        // Reset state
        chk("rst_gnt",   gnt,       3'b000);
        chk("rst_beat",  beat,      3'b000);
        chk("rst_rvld",  rvld,      3'b000);
        chk("rst_busy",  busy,      1'b0);
        chk("rst_en",    sram_en,   1'b0);
        chk("rst_we",    sram_we,   1'b0);
        chk("rst_addr",  sram_addr, 12'h000);
        chk("rst_rdata", rdata,     32'h0);

        // Write burst len=3 from requester 0; req drops after the first beat.
        rst                = 1'b0;
        req                = 3'b001;
        req_we             = 3'b001;
        req_addr[0 +: AW]  = 12'h010;
        req_len[0 +: LW]   = 4'd3;
        for (int i = 0; i < 4; i++) begin
            step();
            req_wdata[0 +: DW] = 32'hC0DE_0000 + i;
            #1;
            chk("wr_gnt",   gnt,        3'b001);
            chk("wr_busy",  busy,       1'b1);
            chk("wr_beat",  beat,       3'b001);
            chk("wr_en",    sram_en,    1'b1);
            chk("wr_we",    sram_we,    1'b1);
            chk("wr_addr",  sram_addr,  12'h010 + i);
            chk("wr_wdata", sram_wdata, 32'hC0DE_0000 + i);
            req = 3'b000;
        end
        step();
        #1;
        chk("wr_end_busy", busy,    1'b0);
        chk("wr_end_gnt",  gnt,     3'b000);
        chk("wr_end_en",   sram_en, 1'b0);
        chk("wr_end_beat", beat,    3'b000);
        chk("wr_mem",      mem[12'h012], 32'hC0DE_0002);

        // Read burst with address wrap, requester 1.
        req                = 3'b010;
        req_we             = 3'b000;
        req_addr[AW +: AW] = 12'hFFE;
        req_len[LW +: LW]  = 4'd2;
        for (int i = 0; i < 3; i++) begin
            step();
            #1;
            chk("rd_addr", sram_addr, wrap_a[i]);
            chk("rd_beat", beat,      3'b010);
            chk("rd_we",   sram_we,   1'b0);
            if (i == 0) begin
                chk("rd_rvld0", rvld, 3'b000);
            end else begin
                chk("rd_rvld",  rvld,  3'b010);
                chk("rd_rdata", rdata, pat(wrap_a[i-1]));
            end
            req = 3'b000;
        end
        step();
        #1;
        chk("rd_tail_busy",  busy,  1'b0);
        chk("rd_tail_rvld",  rvld,  3'b010);
        chk("rd_tail_rdata", rdata, pat(12'h000));
        step();
        #1;
        chk("rd_done_rvld", rvld, 3'b000);

        // Arbitration order with all requesters held, len=0 each.
        rst = 1'b1;
        step();
        rst      = 1'b0;
        req      = 3'b111;
        req_we   = 3'b000;
        req_len  = '0;
        req_addr = {12'h200, 12'h200, 12'h200};
        for (int i = 0; i < 7; i++) begin
            step();
            #1;
            chk("arb_gnt",  gnt,  order[i]);
            chk("arb_busy", busy, order[i] != 3'b000);
        end
        req = 3'b000;
        step();

        // Flush on the third beat of a len=7 read burst from requester 1.
        req                = 3'b010;
        req_addr[AW +: AW] = 12'h100;
        req_len[LW +: LW]  = 4'd7;
        step();
        #1;
        chk("fl_addr0", sram_addr, 12'h100);
        chk("fl_beat0", beat,      3'b010);
        req = 3'b000;
        step();
        #1;
        chk("fl_addr1",  sram_addr, 12'h101);
        chk("fl_rvld1",  rvld,      3'b010);
        chk("fl_rdata1", rdata,     pat(12'h100));
        step();
        flush = 1'b1;
        #1;
        chk("fl_en",    sram_en, 1'b0);
        chk("fl_beat",  beat,    3'b000);
        chk("fl_busy",  busy,    1'b1);
        chk("fl_gnt",   gnt,     3'b010);
        chk("fl_rvld",  rvld,    3'b010);
        chk("fl_rdata", rdata,   pat(12'h101));
        step();
        flush   = 1'b0;
        req     = 3'b111;
        req_len = '0;
        #1;
        chk("fl_idle_busy", busy,    1'b0);
        chk("fl_idle_gnt",  gnt,     3'b000);
        chk("fl_idle_rvld", rvld,    3'b000);
        chk("fl_idle_en",   sram_en, 1'b0);
        step();
        #1;
        chk("fl_next_gnt", gnt, after_flush_gnt);
        req = 3'b000;
        step();

        // Flush in IDLE is ignored; then reset on the second beat.
        flush             = 1'b1;
        req               = 3'b001;
        req_we            = 3'b000;
        req_addr[0 +: AW] = 12'h020;
        req_len[0 +: LW]  = 4'd3;
        step();
        flush = 1'b0;
        #1;
        chk("if_busy", busy,      1'b1);
        chk("if_gnt",  gnt,       3'b001);
        chk("if_addr", sram_addr, 12'h020);
        req = 3'b000;
        step();
        #1;
        chk("rb_addr", sram_addr, 12'h021);
        chk("rb_rvld", rvld,      3'b001);
        rst = 1'b1;
        step();
        #1;
        chk("rb_gnt",   gnt,       3'b000);
        chk("rb_beat",  beat,      3'b000);
        chk("rb_rvld",  rvld,      3'b000);
        chk("rb_busy",  busy,      1'b0);
        chk("rb_en",    sram_en,   1'b0);
        chk("rb_we",    sram_we,   1'b0);
        chk("rb_addr0", sram_addr, 12'h000);
        chk("rb_rdata", rdata,     32'h0);
        rst = 1'b0;
        step();
        #1;
        chk("rb_after_rvld", rvld, 3'b000);
        chk("rb_after_busy", busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
